// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
//  Module   : icache_dm
//  Purpose  : Direct-mapped instruction cache between the core fetch port and
//             a multi-cycle backing instruction memory. Hits are answered
//             combinationally in the same cycle. A miss stalls the core while
//             the whole line is filled word by word over a req/ready
//             handshake. The cache also provides full invalidate (flush) and
//             saturating hit/miss counters.
//  Ports    : clk, rst           - clock, asynchronous active-high reset
//             cpu_req/cpu_addr   - fetch request and byte address
//             cpu_instr/cpu_stall- returned instruction, stall to the core
//             flush              - single-cycle invalidate-all pulse
//             mem_req/mem_addr   - backing-memory word request/address
//             mem_ready/mem_rdata- request completion and read data
//             hit_cnt/miss_cnt   - saturating statistics counters
//  Revision : 1.0 - initial release
// ============================================================================
module icache_dm #(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [31:0]       cpu_instr,
    output logic              cpu_stall,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int c_OB    = $clog2(WORDS_PER_LINE);
    localparam int c_IB    = $clog2(LINES);
    localparam int c_TAG_W = ADDR_W - 2 - c_OB - c_IB;

    localparam logic [c_OB-1:0] c_LAST_WORD = c_OB'(WORDS_PER_LINE - 1);
    localparam logic [31:0]     c_CNT_MAX   = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [LINES-1:0]   r_valid;
    logic [c_TAG_W-1:0] r_tag_mem [LINES];
    logic [31:0]        r_data    [LINES*WORDS_PER_LINE];

    logic [c_TAG_W-1:0] r_fill_tag;
    logic [c_IB-1:0]    r_fill_index;
    logic [c_OB-1:0]    r_word_cnt;
    logic               r_flush_pend;
    logic [31:0]        r_hit_cnt;
    logic [31:0]        r_miss_cnt;

    logic [c_OB-1:0]    w_word;
    logic [c_IB-1:0]    w_index;
    logic [c_TAG_W-1:0] w_tag;
    logic               w_hit;
    logic               w_mem_req;
    logic               w_unused_addr_bits;

    // Byte-offset bits never matter: fetches are always whole words.
    assign w_unused_addr_bits = ^cpu_addr[1:0];

    assign w_word  = cpu_addr[2 +: c_OB];
    assign w_index = cpu_addr[2 + c_OB +: c_IB];
    assign w_tag   = cpu_addr[ADDR_W-1 -: c_TAG_W];

    // Hits are only reported in IDLE so the refetch after DONE is what
    // releases the core, never a partially written line.
    assign w_hit     = r_valid[w_index] && (r_tag_mem[w_index] == w_tag) && (r_state == S_IDLE);
    assign cpu_instr = r_data[{w_index, w_word}];
    assign cpu_stall = cpu_req && !w_hit;

    // The request address is built from the latched fill registers, so it
    // stays stable until mem_ready advances the word counter.
    assign mem_req  = w_mem_req;
    assign mem_addr = {r_fill_tag, r_fill_index, r_word_cnt, 2'b00};
    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;

    always_comb begin
        w_next_state = r_state;
        w_mem_req    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cpu_req && !w_hit) begin
                    w_next_state = S_FILL;
                end
            end
            S_FILL: begin
                w_mem_req = 1'b1;
                if (mem_ready && (r_word_cnt == c_LAST_WORD)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_fill_tag   <= '0;
            r_fill_index <= '0;
            r_word_cnt   <= '0;
            r_flush_pend <= 1'b0;
            r_hit_cnt    <= '0;
            r_miss_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req && w_hit && (r_hit_cnt != c_CNT_MAX)) begin
                        r_hit_cnt <= r_hit_cnt + 32'd1;
                    end
                    if (cpu_req && !w_hit) begin
                        r_fill_tag   <= w_tag;
                        r_fill_index <= w_index;
                        r_word_cnt   <= '0;
                        // The victim line is overwritten in place, so it
                        // must stop hitting as soon as the fill begins.
                        r_valid[w_index] <= 1'b0;
                        if (r_miss_cnt != c_CNT_MAX) begin
                            r_miss_cnt <= r_miss_cnt + 32'd1;
                        end
                    end
                    if (flush) begin
                        r_valid <= '0;
                    end
                end
                S_FILL: begin
                    if (mem_ready) begin
                        r_word_cnt <= r_word_cnt + 1'b1;
                    end
                    if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                end
                S_DONE: begin
                    // A flush seen during the fill wins over the new line:
                    // everything is invalidated and the stalled fetch misses
                    // once more.
                    if (r_flush_pend || flush) begin
                        r_valid <= '0;
                    end else begin
                        r_valid[r_fill_index] <= 1'b1;
                    end
                    r_flush_pend <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Storage arrays carry no reset; validity is tracked by r_valid alone.
    always_ff @(posedge clk) begin
        if ((r_state == S_FILL) && mem_ready) begin
            r_data[{r_fill_index, r_word_cnt}] <= mem_rdata;
        end
        if (r_state == S_DONE) begin
            r_tag_mem[r_fill_index] <= r_fill_tag;
        end
    end

endmodule
`default_nettype wire
